fa_bist_checker: RTL and testbench

//   Synthesizable built-in self-test engine for a 1-bit full adder (x,y,z -> sum,carry).

---
 rtl/fa_bist_checker.sv | 118 +++++++++++
 tb/tb_fa_bist_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_bist_checker.sv
// Built-in self-test engine for a 1-bit full adder: walks all eight input vectors,
// compares the adder's sum/carry against golden values and reports the outcome.
module fa_bist_checker #(
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sum,
  input  logic             carry,
  output logic             x,
  output logic             y,
  output logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_vec,
  output logic             fail_sum,
  output logic             fail_carry
);

  localparam int SC = (SETTLE_CYC < 1) ? 1 : SETTLE_CYC;
  localparam int CW = (SC > 1) ? $clog2(SC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SC - 1);

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t          state;
  logic [2:0]      vec;
  logic [CW-1:0]   cnt;
  logic            first_seen;
  logic            exp_s;
  logic            exp_c;
  logic            mismatch;
  logic [ERR_W-1:0] err_nxt;

  assign {x, y, z} = vec;

  always_comb begin
    exp_s    = ^vec;
    exp_c    = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    mismatch = ({sum, carry} != {exp_s, exp_c});
    err_nxt  = err_cnt;
    if (mismatch && (err_cnt != '1))
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      first_seen <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_vec   <= '0;
      fail_sum   <= 1'b0;
      fail_carry <= 1'b0;
    end else if (abort) begin
      // Partial err_cnt/fail_* are kept for inspection after an abort.
      state <= IDLE;
      vec   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_sum   <= 1'b0;
            fail_carry <= 1'b0;
            first_seen <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec        <= '0;
            cnt        <= RELOAD;
            busy       <= 1'b1;
            state      <= APPLY;
          end
        end
        APPLY: begin
          if (cnt == '0)
            state <= CHECK;
          else
            cnt <= cnt - 1'b1;
        end
        CHECK: begin
          err_cnt <= err_nxt;
          if (mismatch && !first_seen) begin
            first_seen <= 1'b1;
            fail_vec   <= vec;
            fail_sum   <= sum;
            fail_carry <= carry;
          end
          if (vec == 3'd7) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == '0);
          end else begin
            vec   <= vec + 1'b1;
            cnt   <= RELOAD;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Bench for fa_bist_checker: two instances (default and SETTLE_CYC=0/ERR_W=2) share
// stimulus, each driving a faultable full-adder model selected by per-vector masks.
module tb_fa_bist_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;

  logic x1, y1, z1, sum1, carry1, busy1, done1, pass1, fsum1, fcar1;
  logic [3:0] err1;
  logic [2:0] fv1;
  logic x2, y2, z2, sum2, carry2, busy2, done2, pass2, fsum2, fcar2;
  logic [1:0] err2;
  logic [2:0] fv2;

  logic [7:0] fs_m = '0;
  logic [7:0] fc_m = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fa_bist_checker dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sum(sum1), .carry(carry1), .x(x1), .y(y1), .z(z1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .fail_vec(fv1), .fail_sum(fsum1), .fail_carry(fcar1)
  );

  fa_bist_checker #(.SETTLE_CYC(0), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sum(sum2), .carry(carry2), .x(x2), .y(y2), .z(z2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .fail_vec(fv2), .fail_sum(fsum2), .fail_carry(fcar2)
  );

  // Adder under test: true full adder with per-vector sum/carry inversion masks.
  always_comb begin
    sum1   = (x1 ^ y1 ^ z1) ^ fs_m[{x1, y1, z1}];
    carry1 = ((x1 & y1) | (x1 & z1) | (y1 & z1)) ^ fc_m[{x1, y1, z1}];
    sum2   = (x2 ^ y2 ^ z2) ^ fs_m[{x2, y2, z2}];
    carry2 = ((x2 & y2) | (x2 & z2) | (y2 & z2)) ^ fc_m[{x2, y2, z2}];
  end

  typedef struct {
    string      name;
    logic [7:0] fs;
    logic [7:0] fc;
    int         e4;
    int         e2;
    int         fv;
    int         fsum;
    int         fcar;
    int         pass;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge; pulses start and measures done latency for both DUTs.
  task automatic run(input bit chk_seq, input int poke_at, output int lat1, output int lat2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1;
    lat2 = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == poke_at) start = 1'b1;
      if (n == poke_at + 1) start = 1'b0;
      @(posedge clk); #1;
      if (chk_seq && lat1 < 0 && n < 24) begin
        chk("xyz_step", {x1, y1, z1}, n / 3);
        chk("busy_run", busy1, 1);
      end
      if (done1 && lat1 < 0) lat1 = n;
      if (done2 && lat2 < 0) lat2 = n;
      if (lat1 >= 0 && lat2 >= 0) break;
    end
    start = 1'b0;
    chk("done_latency", lat1, 24);
    chk("done_latency_s0", lat2, 16);
  endtask

  task automatic check_done(input string nm, input int e4, input int e2, input int fv,
                            input int fsum, input int fcar, input int ps);
    chk({nm, ".err_cnt"}, err1, e4);
    chk({nm, ".err_cnt_w2"}, err2, e2);
    chk({nm, ".fail_vec"}, fv1, fv);
    chk({nm, ".fail_vec_w2"}, fv2, fv);
    chk({nm, ".fail_sum"}, fsum1, fsum);
    chk({nm, ".fail_carry"}, fcar1, fcar);
    chk({nm, ".fail_carry_w2"}, fcar2, fcar);
    chk({nm, ".pass"}, pass1, ps);
    chk({nm, ".pass_w2"}, pass2, ps);
    chk({nm, ".busy"}, busy1, 0);
  endtask

  // Reference: outcome derived directly from which vectors are faulty.
  task automatic check_model(input string nm);
    int cnt;
    int first;
    int fsum;
    int fcar;
    cnt = 0;
    first = -1;
    for (int i = 0; i < 8; i++) begin
      if (fs_m[i] || fc_m[i]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    fsum = 0;
    fcar = 0;
    if (first >= 0) begin
      fsum = ($countones(first) % 2) ^ int'(fs_m[first]);
      fcar = ($countones(first) >= 2 ? 1 : 0) ^ int'(fc_m[first]);
    end
    check_done(nm, cnt > 15 ? 15 : cnt, cnt > 3 ? 3 : cnt, first < 0 ? 0 : first,
               fsum, fcar, cnt == 0 ? 1 : 0);
  endtask

  initial begin
    int l1;
    int l2;

    tbl[0] = '{"correct",   8'h00, 8'h00, 0, 0, 0, 0, 0, 1};
    tbl[1] = '{"sum_sa0",   8'h96, 8'h00, 4, 3, 1, 0, 0, 0};
    tbl[2] = '{"carry_inv", 8'h00, 8'hFF, 8, 3, 0, 0, 1, 0};
    tbl[3] = '{"sum_v7",    8'h80, 8'h00, 1, 1, 7, 0, 1, 0};
    tbl[4] = '{"both_v5",   8'h20, 8'h20, 1, 1, 5, 1, 0, 0};

    #12;
    chk("rst.busy", busy1, 0);
    chk("rst.done", done1, 0);
    chk("rst.pass", pass1, 0);
    chk("rst.xyz", {x1, y1, z1}, 0);
    chk("rst.err", err1, 0);
    chk("rst.fail", {fv1, fsum1, fcar1}, 0);
    chk("rst.w2", {busy2, done2, pass2, err2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven fault scenarios
    for (int i = 0; i < 5; i++) begin
      fs_m = tbl[i].fs;
      fc_m = tbl[i].fc;
      run(i == 0, -1, l1, l2);
      check_done(tbl[i].name, tbl[i].e4, tbl[i].e2, tbl[i].fv,
                 tbl[i].fsum, tbl[i].fcar, tbl[i].pass);
      chk({tbl[i].name, ".done"}, done1, 1);
    end

    // Abort during the vec=3 APPLY phase
    fs_m = 8'h00;
    fc_m = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("abort.pre_vec", {x1, y1, z1}, 3);
    chk("abort.pre_busy", busy1, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort.busy", busy1, 0);
    chk("abort.done", done1, 0);
    chk("abort.pass", pass1, 0);
    chk("abort.xyz", {x1, y1, z1}, 0);
    chk("abort.err_hold", err1, 3);
    chk("abort.err_hold_w2", err2, 3);
    chk("abort.fcar_hold", fcar1, 1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("abort.idle_busy", busy1, 0);
    fc_m = 8'h00;
    run(1'b0, -1, l1, l2);
    check_done("after_abort", 0, 0, 0, 0, 0, 1);

    // Abort from DONE clears done/pass
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done.done", done1, 0);
    chk("abort_done.pass", pass1, 0);

    // Asynchronous reset mid-run
    fc_m = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("rstmid.pre_err", err1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", busy1, 0);
    chk("rstmid.err", err1, 0);
    chk("rstmid.xyz", {x1, y1, z1}, 0);
    chk("rstmid.fail", {fv1, fsum1, fcar1}, 0);
    chk("rstmid.w2", {busy2, err2, x2, y2, z2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // start + abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort.busy", busy1, 0);
    @(posedge clk); #1;
    chk("start_abort.busy2", busy1, 0);
    chk("start_abort.done", done1, 0);

    // start while busy must not restart the run
    fc_m = 8'h00;
    run(1'b1, 5, l1, l2);
    check_done("start_busy", 0, 0, 0, 0, 0, 1);

    // Randomized fault masks against the reference model
    for (int r = 0; r < 20; r++) begin
      fs_m = 8'($urandom);
      fc_m = 8'($urandom);
      if (r % 4 == 0) fs_m = '0;
      if (r % 5 == 0) fc_m = '0;
      run(1'b0, -1, l1, l2);
      check_model($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
